// File: rtl/key_click_ctrl.sv
// key_click_ctrl: push-button gesture controller.
// Synchronises and debounces an active-low key, classifies each gesture as
// SINGLE, DOUBLE or LONG, and hands events to a consumer through a one-entry
// valid/ready register. Events produced while that register is full are
// discarded and flagged with a one-cycle evt_drop pulse.
module key_click_ctrl #(
  parameter int DEB_CNT  = 1_000_000,
  parameter int GAP_CNT  = 15_000_000,
  parameter int LONG_CNT = 50_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_in,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  output logic       evt_drop,
  output logic       key_level,
  output logic       busy
);

  // Both timers share one width, sized for the longest interval.
  localparam int MAX_DG  = (DEB_CNT > GAP_CNT) ? DEB_CNT : GAP_CNT;
  localparam int MAX_CNT = (MAX_DG > LONG_CNT) ? MAX_DG : LONG_CNT;
  localparam int CW      = $clog2(MAX_CNT);

  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_SAT   = {CW{1'b1}};
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CNT - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CNT - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CNT - 1);

  localparam logic [1:0] EVT_NONE   = 2'b00;
  localparam logic [1:0] EVT_SINGLE = 2'b01;
  localparam logic [1:0] EVT_DOUBLE = 2'b10;
  localparam logic [1:0] EVT_LONG   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,  // key released, no gesture in progress
    ST_PDEB = 3'd1,  // debouncing a press
    ST_HELD = 3'd2,  // press accepted, key held
    ST_RDEB = 3'd3,  // debouncing a release
    ST_GAP  = 3'd4   // first click done, waiting for a possible second press
  } state_t;

  // Saturating increment: the hold/gap timer must never wrap back to zero,
  // otherwise a very long hold could alias onto the LONG threshold again.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] val);
    logic [CW-1:0] res;
    if (val == CNT_SAT) begin
      res = val;
    end else begin
      res = val + CNT_ONE;
    end
    return res;
  endfunction

  // Synchroniser and FSM state
  logic          sync_meta_r;
  logic          key_sync_r;
  state_t        state_r;
  state_t        state_nxt_s;
  logic [CW-1:0] deb_cnt_r;
  logic [CW-1:0] deb_cnt_nxt_s;
  logic [CW-1:0] tm_cnt_r;
  logic [CW-1:0] tm_cnt_nxt_s;
  logic          clicks_r;
  logic          clicks_nxt_s;
  logic          long_flag_r;
  logic          long_flag_nxt_s;
  logic          key_level_r;
  logic          key_level_nxt_s;
  logic          busy_r;
  logic          busy_nxt_s;

  // FSM emit request for this cycle
  logic          emit_s;
  logic [1:0]    emit_code_s;

  // Event register
  logic          evt_valid_r;
  logic          evt_valid_nxt_s;
  logic [1:0]    evt_code_r;
  logic [1:0]    evt_code_nxt_s;
  logic          evt_drop_r;
  logic          evt_drop_nxt_s;

  // Two-flop synchroniser for the asynchronous key input; idles high (released).
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      sync_meta_r <= 1'b1;
      key_sync_r  <= 1'b1;
    end else begin
      sync_meta_r <= key_in;
      key_sync_r  <= sync_meta_r;
    end
  end

  // Gesture FSM next-state, timer, flag and emit decisions (one decision per edge).
  always_comb begin
    state_nxt_s     = state_r;
    deb_cnt_nxt_s   = deb_cnt_r;
    tm_cnt_nxt_s    = tm_cnt_r;
    clicks_nxt_s    = clicks_r;
    long_flag_nxt_s = long_flag_r;
    key_level_nxt_s = key_level_r;
    emit_s          = 1'b0;
    emit_code_s     = EVT_NONE;

    case (state_r)
      ST_IDLE: begin
        if (!key_sync_r) begin
          state_nxt_s   = ST_PDEB;
          deb_cnt_nxt_s = CNT_ZERO;
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end

      ST_PDEB: begin
        if (key_sync_r) begin
          // Press bounced away. The gap timer is deliberately left alone so
          // a failed second press does not extend the double-click window.
          if (clicks_r) begin
            state_nxt_s = ST_GAP;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else if (deb_cnt_r == DEB_LAST) begin
          state_nxt_s     = ST_HELD;
          key_level_nxt_s = 1'b0;
          if (!clicks_r) begin
            // First press: start timing the hold for LONG detection.
            tm_cnt_nxt_s = CNT_ZERO;
          end else begin
            tm_cnt_nxt_s = tm_cnt_r;
          end
        end else begin
          deb_cnt_nxt_s = deb_cnt_r + CNT_ONE;
        end
      end

      ST_HELD: begin
        tm_cnt_nxt_s = sat_inc(tm_cnt_r);
        // LONG fires while the key is still down, and only once per gesture.
        if (!clicks_r && (tm_cnt_r == LONG_LAST) && !long_flag_r) begin
          emit_s          = 1'b1;
          emit_code_s     = EVT_LONG;
          long_flag_nxt_s = 1'b1;
        end else begin
          long_flag_nxt_s = long_flag_r;
        end
        if (key_sync_r) begin
          state_nxt_s   = ST_RDEB;
          deb_cnt_nxt_s = CNT_ZERO;
        end else begin
          state_nxt_s   = ST_HELD;
        end
      end

      ST_RDEB: begin
        if (!key_sync_r) begin
          // Release bounced; the hold timer simply carries on.
          state_nxt_s = ST_HELD;
        end else if (deb_cnt_r == DEB_LAST) begin
          key_level_nxt_s = 1'b1;
          if (long_flag_r) begin
            // The LONG was already reported; the release ends the gesture.
            state_nxt_s     = ST_IDLE;
            long_flag_nxt_s = 1'b0;
            clicks_nxt_s    = 1'b0;
          end else if (!clicks_r) begin
            state_nxt_s  = ST_GAP;
            clicks_nxt_s = 1'b1;
            tm_cnt_nxt_s = CNT_ZERO;
          end else begin
            state_nxt_s  = ST_IDLE;
            clicks_nxt_s = 1'b0;
            emit_s       = 1'b1;
            emit_code_s  = EVT_DOUBLE;
          end
        end else begin
          deb_cnt_nxt_s = deb_cnt_r + CNT_ONE;
        end
      end

      ST_GAP: begin
        if (!key_sync_r) begin
          state_nxt_s   = ST_PDEB;
          deb_cnt_nxt_s = CNT_ZERO;
        end else if (tm_cnt_r == GAP_LAST) begin
          state_nxt_s  = ST_IDLE;
          clicks_nxt_s = 1'b0;
          emit_s       = 1'b1;
          emit_code_s  = EVT_SINGLE;
        end else begin
          tm_cnt_nxt_s = sat_inc(tm_cnt_r);
        end
      end

      default: begin
        // Unreachable encoding: recover to a clean idle state.
        state_nxt_s     = ST_IDLE;
        deb_cnt_nxt_s   = CNT_ZERO;
        tm_cnt_nxt_s    = CNT_ZERO;
        clicks_nxt_s    = 1'b0;
        long_flag_nxt_s = 1'b0;
        key_level_nxt_s = 1'b1;
      end
    endcase

    busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // FSM state, timers, flags and the debounced level / busy outputs.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_r     <= ST_IDLE;
      deb_cnt_r   <= CNT_ZERO;
      tm_cnt_r    <= CNT_ZERO;
      clicks_r    <= 1'b0;
      long_flag_r <= 1'b0;
      key_level_r <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      deb_cnt_r   <= deb_cnt_nxt_s;
      tm_cnt_r    <= tm_cnt_nxt_s;
      clicks_r    <= clicks_nxt_s;
      long_flag_r <= long_flag_nxt_s;
      key_level_r <= key_level_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  // Event register next state: load, hand over, or drop on overflow.
  always_comb begin
    evt_valid_nxt_s = evt_valid_r;
    evt_code_nxt_s  = evt_code_r;
    evt_drop_nxt_s  = 1'b0;
    if (emit_s) begin
      if (!evt_valid_r || evt_ready) begin
        // Empty, or the held event leaves this cycle: take the new one.
        evt_valid_nxt_s = 1'b1;
        evt_code_nxt_s  = emit_code_s;
      end else begin
        // Full and stalled: keep the held event, report the loss.
        evt_drop_nxt_s  = 1'b1;
      end
    end else if (evt_valid_r && evt_ready) begin
      evt_valid_nxt_s = 1'b0;
      evt_code_nxt_s  = EVT_NONE;
    end else begin
      evt_valid_nxt_s = evt_valid_r;
      evt_code_nxt_s  = evt_code_r;
    end
  end

  // Event register flops.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      evt_valid_r <= 1'b0;
      evt_code_r  <= EVT_NONE;
      evt_drop_r  <= 1'b0;
    end else begin
      evt_valid_r <= evt_valid_nxt_s;
      evt_code_r  <= evt_code_nxt_s;
      evt_drop_r  <= evt_drop_nxt_s;
    end
  end

  assign evt_valid = evt_valid_r;
  assign evt_code  = evt_code_r;
  assign evt_drop  = evt_drop_r;
  assign key_level = key_level_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_key_click_ctrl.sv
// Self-checking bench for key_click_ctrl (DEB_CNT=4, GAP_CNT=20, LONG_CNT=40).
// Gestures are described as press/release lengths; expected event times,
// debounced level and busy windows are derived from those lengths with plain
// arithmetic, and the one-entry event register is tracked cycle by cycle.
module tb_key_click_ctrl;

  localparam int DEB  = 4;
  localparam int GAP  = 20;
  localparam int LNG  = 40;
  localparam int LEAD = 4;
  localparam int NMAX = 2048;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       key_in;
  logic       evt_ready;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_drop;
  logic       key_level;
  logic       busy;

  int checks;
  int errors;

  logic       wave     [NMAX];
  logic       rdyw     [NMAX];
  logic       exp_lvl  [NMAX];
  logic       exp_busy [NMAX];
  logic [1:0] exp_emit [NMAX];
  int         pl[$];
  int         gl[$];

  logic       m_v;
  logic [1:0] m_c;
  logic       m_d;

  key_click_ctrl #(
    .DEB_CNT (DEB),
    .GAP_CNT (GAP),
    .LONG_CNT(LNG)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_in   (key_in),
    .evt_ready(evt_ready),
    .evt_valid(evt_valid),
    .evt_code (evt_code),
    .evt_drop (evt_drop),
    .key_level(key_level),
    .busy     (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input string what, input logic [1:0] obs, input logic [1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s.%s observed=%0b expected=%0b at t=%0t", tag, what, obs, exp_v, $time);
    end
  endtask

  // Build expectations from the gesture list and replay it cycle by cycle.
  // rmode: 0 ready always high, 1 random ready, 2 ready low until the last 20 cycles.
  task automatic run_scn(input string tag, input int rmode);
    int n, t, a, r, a1, pend;
    n = LEAD;
    foreach (pl[k]) n += pl[k] + gl[k];
    if (n > NMAX) begin
      $display("FAIL %s.length observed=%0d expected<=%0d", tag, n, NMAX);
      $fatal(1, "scenario too long");
    end
    for (int i = 0; i < n; i++) begin
      wave[i]     = 1'b1;
      exp_lvl[i]  = 1'b1;
      exp_busy[i] = 1'b0;
      exp_emit[i] = 2'b00;
      case (rmode)
        0:       rdyw[i] = 1'b1;
        1:       rdyw[i] = ($urandom_range(0, 3) != 0);
        default: rdyw[i] = (i >= n - 20);
      endcase
    end
    t = LEAD; pend = 0; a1 = 0;
    foreach (pl[k]) begin
      a = t;
      r = a + pl[k];
      for (int i = a; i < r; i++) wave[i] = 1'b0;
      // Level follows each accepted change DEB+3 edges after it is first sampled.
      for (int i = a + DEB + 2; i <= r + DEB + 1; i++) exp_lvl[i] = 1'b0;
      if (pend != 0) begin
        // Second press of a pair: DOUBLE when its release is debounced.
        exp_emit[r + DEB + 2] = 2'b10;
        for (int i = a1 + 2; i <= r + DEB + 1; i++) exp_busy[i] = 1'b1;
        pend = 0;
      end else if (pl[k] >= LNG + DEB) begin
        exp_emit[a + DEB + 2 + LNG] = 2'b11;
        for (int i = a + 2; i <= r + DEB + 1; i++) exp_busy[i] = 1'b1;
      end else if (gl[k] > GAP + DEB) begin
        exp_emit[r + DEB + 2 + GAP] = 2'b01;
        for (int i = a + 2; i <= r + DEB + 1 + GAP; i++) exp_busy[i] = 1'b1;
      end else begin
        pend = 1;
        a1 = a;
      end
      t = r + gl[k];
    end
    for (int i = 0; i < n; i++) begin
      key_in    = wave[i];
      evt_ready = rdyw[i];
      @(posedge sys_clk);
      m_d = 1'b0;
      if (exp_emit[i] != 2'b00) begin
        if (!m_v || rdyw[i]) begin
          m_v = 1'b1;
          m_c = exp_emit[i];
        end else begin
          m_d = 1'b1;
        end
      end else if (m_v && rdyw[i]) begin
        m_v = 1'b0;
        m_c = 2'b00;
      end
      #1;
      chk(tag, "evt_valid", {1'b0, evt_valid}, {1'b0, m_v});
      chk(tag, "evt_code",  evt_code,          m_c);
      chk(tag, "evt_drop",  {1'b0, evt_drop},  {1'b0, m_d});
      chk(tag, "key_level", {1'b0, key_level}, {1'b0, exp_lvl[i]});
      chk(tag, "busy",      {1'b0, busy},      {1'b0, exp_busy[i]});
      @(negedge sys_clk);
    end
    pl.delete();
    gl.delete();
  endtask

  initial begin
    checks = 0; errors = 0;
    m_v = 1'b0; m_c = 2'b00; m_d = 1'b0;
    key_in = 1'b1; evt_ready = 1'b1; sys_rst_n = 1'b0;

    // Reset with the key toggling
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      key_in = ~key_in;
    end
    @(posedge sys_clk);
    #1;
    chk("reset", "key_level", {1'b0, key_level}, 2'b01);
    chk("reset", "evt_valid", {1'b0, evt_valid}, 2'b00);
    chk("reset", "evt_code",  evt_code,          2'b00);
    chk("reset", "evt_drop",  {1'b0, evt_drop},  2'b00);
    chk("reset", "busy",      {1'b0, busy},      2'b00);
    @(negedge sys_clk);
    key_in = 1'b1;
    sys_rst_n = 1'b1;

    // Directed gestures
    pl = '{10};      gl = '{40};     run_scn("single", 0);
    pl = '{10, 10};  gl = '{8, 40};  run_scn("double", 0);
    pl = '{60};      gl = '{40};     run_scn("long", 0);
    pl = '{43};      gl = '{40};     run_scn("hold43", 0);
    pl = '{44};      gl = '{40};     run_scn("hold44", 0);
    pl = '{10, 10};  gl = '{24, 40}; run_scn("gap24", 0);
    pl = '{10, 10};  gl = '{25, 40}; run_scn("gap25", 0);
    pl = '{10, 60};  gl = '{8, 40};  run_scn("dbl_long2", 0);

    // Bounce rejection: low 2, high 1, low 2, then high
    evt_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      key_in = (i == 2 || i >= 5) ? 1'b1 : 1'b0;
      @(posedge sys_clk);
      #1;
      chk("bounce", "key_level", {1'b0, key_level}, 2'b01);
      chk("bounce", "evt_valid", {1'b0, evt_valid}, 2'b00);
      @(negedge sys_clk);
    end
    chk("bounce", "busy", {1'b0, busy}, 2'b00);

    // Backpressure: SINGLE held, LONG dropped, then ready releases it
    pl = '{10, 60}; gl = '{30, 40}; run_scn("backpr", 2);

    // Reset during the gap after a single click aborts the gesture
    for (int i = 0; i < 26; i++) begin
      key_in = (i < 10) ? 1'b0 : 1'b1;
      @(posedge sys_clk);
      @(negedge sys_clk);
    end
    chk("rst_gap", "busy_before", {1'b0, busy}, 2'b01);
    sys_rst_n = 1'b0;
    @(posedge sys_clk);
    @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge sys_clk);
      #1;
      chk("rst_gap", "evt_valid", {1'b0, evt_valid}, 2'b00);
      chk("rst_gap", "busy",      {1'b0, busy},      2'b00);
      chk("rst_gap", "key_level", {1'b0, key_level}, 2'b01);
      @(negedge sys_clk);
    end
    m_v = 1'b0; m_c = 2'b00;

    // Random gesture stream with random ready
    for (int k = 0; k < 10; k++) begin
      pl.push_back(($urandom_range(0, 9) < 6) ? int'($urandom_range(6, 43)) : int'($urandom_range(44, 70)));
      gl.push_back((k == 9) ? 40 : int'($urandom_range(6, 40)));
    end
    run_scn("random", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_click_ctrl.md
Name: key_click_ctrl

Overview:
- Controller for one active-low push-button. Sequences debounce, hold-time and inter-click gap timing.
- Classifies each gesture as SINGLE, DOUBLE or LONG press.
- Delivers events through a one-entry valid/ready register to downstream consumers (LED/mode logic, counters).
- Replaces ad-hoc per-design debounce/double-press logic with one reusable, handshaked block.

Parameters:
- DEB_CNT, 1_000_000: cycles a new level must stay stable to be accepted (20 ms at 50 MHz). Legal range ≥ 2.
- GAP_CNT, 15_000_000: cycles after the first release within which a second press makes a DOUBLE (300 ms). Legal range ≥ 2.
- LONG_CNT, 50_000_000: cycles a first press must be held to make a LONG (1 s). Must be > DEB_CNT.

Ports:
- sys_clk  in  1  clock; all logic on rising edge
- sys_rst_n  in  1  reset; synchronous, active-low
- key_in  in  1  raw asynchronous button; 0 = pressed
- evt_ready  in  1  consumer accepts the event when high with evt_valid
- evt_valid  out  1  event register holds an unconsumed event
- evt_code  out  2  2'b01 SINGLE, 2'b10 DOUBLE, 2'b11 LONG; 2'b00 whenever evt_valid = 0
- evt_drop  out  1  one-cycle pulse: an event was produced while the register was full, and was discarded
- key_level  out  1  debounced key level; 0 = pressed
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: sync flops = 1, key_level = 1, evt_valid = 0, evt_code = 0, evt_drop = 0, busy = 0, FSM = IDLE. All counters and flags = 0.
- Reset asserted mid-gesture aborts it; no event is produced.
- Synchroniser: 2 flops, key_in → key_s.
- Counters:
  - deb_cnt and tm_cnt, each $clog2(max(DEB_CNT, GAP_CNT, LONG_CNT)) bits.
  - tm_cnt saturates at its terminal value; it never wraps.
- Flags: clicks (0/1), long_flag.
- FSM transitions, one decision per edge:
  - IDLE: key_s = 0 → PDEB, deb_cnt = 0.
  - PDEB:
    - key_s = 1 → IDLE if clicks = 0, else GAP. tm_cnt is not cleared.
    - key_s = 0 and deb_cnt = DEB_CNT-1 → HELD, key_level = 0. If clicks = 0, tm_cnt = 0.
    - otherwise deb_cnt++.
  - HELD:
    - tm_cnt++ up to saturation.
    - If clicks = 0 and tm_cnt = LONG_CNT-1 and long_flag = 0: emit LONG, set long_flag. LONG fires while the key is still held.
    - key_s = 1 → RDEB, deb_cnt = 0.
  - RDEB:
    - key_s = 0 → HELD. Bounce; tm_cnt continues.
    - key_s = 1 and deb_cnt = DEB_CNT-1: key_level = 1, then:
      - long_flag = 1 → IDLE; clear long_flag and clicks.
      - clicks = 0 → clicks = 1, tm_cnt = 0 → GAP.
      - clicks = 1 → emit DOUBLE → IDLE; clear clicks.
    - otherwise deb_cnt++.
  - GAP:
    - key_s = 0 → PDEB, deb_cnt = 0.
    - else if tm_cnt = GAP_CNT-1 → emit SINGLE → IDLE; clear clicks.
    - else tm_cnt++.
- A second press held beyond LONG_CNT still yields DOUBLE on release; LONG applies to the first press only.
- The gap timer keeps running through a failed (bounced) second-press debounce.
- Latency:
  - key_level changes exactly DEB_CNT+3 rising edges after the first edge that samples the new, stable key_in level.
  - An event is visible on evt_valid/evt_code from the edge on which the FSM decides to emit it.
- Event register:
  - Loads on emit when evt_valid = 0, or when evt_valid & evt_ready in the same cycle; evt_valid stays 1 in the latter case.
  - evt_valid & evt_ready with no emit → evt_valid = 0, evt_code = 0.
  - Emit while evt_valid = 1 and evt_ready = 0 → new event discarded, evt_drop = 1 for one cycle. The held event is unchanged.
- evt_valid/evt_code are stable while evt_valid = 1 and evt_ready = 0.
- evt_ready is ignored while evt_valid = 0.

Test Plan (DEB_CNT=4, GAP_CNT=20, LONG_CNT=40, evt_ready tied 1 unless stated):
- Reset state: hold sys_rst_n = 0 for 3 cycles, key_in toggling → key_level = 1, evt_valid = 0, busy = 0, no evt_drop.
- Clean SINGLE: key_in low for 10 cycles, then high → key_level low then high at DEB_CNT+3 = 7 edges after each change. evt_code = 01 pulses once, 20 cycles after the release is debounced.
- Bounce rejection: key_in low 2 cycles, high 1, low 2, then high → key_level stays 1, no event, busy returns to 0.
- DOUBLE: press 10, release 8, press 10, release → exactly one evt_code = 10 on the second debounced release; no SINGLE emitted.
- LONG: key_in low for 60 cycles → evt_code = 11 while the key is held, at tm_cnt = 39. Release produces no further event.
- Backpressure and reset: evt_ready = 0, SINGLE then LONG → evt_code holds 01, evt_drop pulses once at the LONG decision. Raise evt_ready → valid clears the next cycle. Separately, assert reset during GAP → no event afterward.
